// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 16;

  // Width of a binary index able to address n requesters (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW:0]   pos;
  logic [IW-1:0] cand;
  logic          found;

  // Scan N positions starting at ptr; pos is one bit wider so the wrap compare cannot overflow.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end else begin
        pos = pos;
      end
      cand = pos[IW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Round-robin sharing of one APB master port between NUM_REQ requesters.
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_slverr,
  output logic [AW-1:0]         paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DW-1:0]         pwdata,
  input  logic [DW-1:0]         prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int IW = idx_w(NUM_REQ);

  apb_state_e           state, state_nxt;
  logic [IW-1:0]        ptr, win_idx, grant_idx;
  logic [NUM_REQ-1:0]   grant, win_onehot;
  logic                 accept, done, abort, timeout_hit;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;
  logic                 sel_write;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  // Route the winner's request fields to the address/data registers.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
        sel_write = req_write[i];
      end else begin
        sel_addr  = sel_addr;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // Next-state logic; acceptance is suppressed while reset is asserted.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if ((|req_valid) && presetn) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = ACCESS;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = accept ? grant : '0;

  // FSM, pointer, APB bus registers and one-cycle response pulse.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      ptr        <= '0;
      win_idx    <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      state     <= state_nxt;
      psel      <= (state_nxt != IDLE);
      penable   <= (state_nxt == ACCESS);
      rsp_valid <= '0;
      if (accept) begin
        paddr   <= sel_addr;
        pwdata  <= sel_wdata;
        pwrite  <= sel_write;
        win_idx <= grant_idx;
        ptr     <= (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + IW'(1);
      end
      if (done) begin
        rsp_valid  <= win_onehot;
        rsp_rdata  <= pwrite ? '0 : prdata;
        rsp_slverr <= pslverr;
      end else if (abort) begin
        rsp_valid  <= win_onehot;
        rsp_rdata  <= '0;
        rsp_slverr <= 1'b1;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // Counts stalled ACCESS cycles; cleared while in SETUP, i.e. on ACCESS entry.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state == ACCESS) && !pready && (to_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
